spi_master_handshake: RTL and testbench

Initiator end of the FPGA SPI link handshake: requests a transfer by raising `ready` to the slave, waits for the slave's `start` acknowledge, then shifts one word out on MOSI while capturing MISO (SPI mode 0, MSB first), and closes the exchange with a one-cycle `done` pulse that returns the slave to its idle state. It sits on the master side, between the local command logic (`send`/`tx_data`) and the SPI pins, and drives the `ready`/`done` signals consumed by the slave's handshake block.

---
 rtl/spi_master_handshake.sv | 143 ++++++++++++++
 tb/tb_spi_master_handshake.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_handshake.sv
// SPI mode-0 master with a ready/start/done handshake toward the slave.
// States: IDLE wait send | REQ ready up, await start | SHIFT clock word | DONE pulse done | ERR pulse err.
`timescale 1ns/1ps
module spi_master_handshake #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              ready,
  input  logic              start,
  output logic              done,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              err
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int DIV_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam int TG_W  = $clog2(2 * DATA_W);

  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [TG_W-1:0]  TG_LAST  = TG_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SHIFT,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [TO_W-1:0]   to_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [TG_W-1:0]   tg_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      to_cnt   <= '0;
      div_cnt  <= '0;
      tg_cnt   <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      err      <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_data  <= '0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (send) begin
            tx_sr  <= tx_data;
            to_cnt <= TO_LOAD;
            busy   <= 1'b1;
            ready  <= 1'b1;
            state  <= S_REQ;
          end
        end
        // Down-counter loaded with TIMEOUT: REQ lasts at most TIMEOUT+1 cycles,
        // and a start seen on the last of them still wins.
        S_REQ: begin
          if (start) begin
            ready   <= 1'b0;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= tx_sr[DATA_W-1];
            tx_sr   <= tx_sr << 1;
            div_cnt <= DIV_LOAD;
            tg_cnt  <= '0;
            state   <= S_SHIFT;
          end else if (to_cnt == '0) begin
            ready <= 1'b0;
            err   <= 1'b1;
            state <= S_ERR;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
        end
        S_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            sclk    <= ~sclk;
            tg_cnt  <= tg_cnt + TG_W'(1);
            if (!sclk) begin
              rx_sr <= (rx_sr << 1) | DATA_W'(miso);
            end else begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= tx_sr << 1;
            end
            if (tg_cnt == TG_LAST) begin
              tg_cnt   <= '0;
              cs_n     <= 1'b1;
              mosi     <= 1'b0;
              done     <= 1'b1;
              rx_valid <= 1'b1;
              rx_data  <= rx_sr;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          ready <= 1'b0;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_handshake.sv
// Randomized bench for spi_master_handshake: stimulus pushes expected transfers,
// a sampling monitor pops and checks them on every done/err pulse.
`timescale 1ns/1ps
module tb_spi_master_handshake;
  localparam int DW = 8;
  localparam int CD = 4;
  localparam int TO = 10;
  localparam int SHIFT_CYC = 2 * DW * CD;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    int            req;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          send = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          busy, ready, done, cs_n, sclk, mosi, rx_valid, err;
  logic          start, miso;
  logic [DW-1:0] rx_data;

  logic          start_man = 1'b0;
  logic          auto_start = 1'b0;
  logic          auto_s = 1'b0;
  logic [DW-1:0] cur_rx = '0;
  int            bit_idx = 0;

  int total = 0;
  int bad = 0;
  int n_req = 0;
  int ready_rises = 0;
  int n_done = 0;
  int cyc = 0;
  int done_cyc[$];
  exp_t sb[$];

  spi_master_handshake #(.DATA_W(DW), .CLK_DIV(CD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .send(send), .tx_data(tx_data), .busy(busy),
    .ready(ready), .start(start), .done(done), .cs_n(cs_n), .sclk(sclk),
    .mosi(mosi), .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Slave model: immediate start when enabled, MISO presents the next bit after each SCLK rise.
  always @(negedge clk) auto_s <= auto_start & ready;
  assign start = start_man | auto_s;
  assign miso  = (bit_idx < DW) ? cur_rx[DW-1-bit_idx] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int ready_cnt = 0, shift_cnt = 0, nbits = 0;
    logic [DW-1:0] mosi_word = '0, last_rx = '0;
    logic prev_sclk = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        ready_cnt = 0; shift_cnt = 0; nbits = 0; mosi_word = '0;
        bit_idx = 0; last_rx = '0;
        prev_sclk = 1'b0; prev_ready = 1'b0; prev_done = 1'b0;
      end else begin
        if (ready) ready_cnt++;
        if (ready && !prev_ready) ready_rises++;
        if (!cs_n) shift_cnt++;
        if (sclk && !prev_sclk) begin
          mosi_word = {mosi_word[DW-2:0], mosi};
          nbits++;
          bit_idx++;
        end
        if (cs_n) bit_idx = 0;
        if (done) begin
          chk("done_width", {31'd0, prev_done}, 32'd0);
          chk("rx_valid_with_done", {31'd0, rx_valid}, 32'd1);
          n_done++;
          done_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: actual=done required=none");
          end else begin
            e = sb.pop_front();
            chk("kind_done", {31'd0, e.is_err}, 32'd0);
            chk("mosi_word", mosi_word, e.tx);
            chk("rx_data", rx_data, e.rx);
            chk("sclk_rises", nbits, DW);
            chk("shift_len", shift_cnt, SHIFT_CYC);
            chk("req_len", ready_cnt, e.req);
            last_rx = e.rx;
          end
          ready_cnt = 0; shift_cnt = 0; nbits = 0; mosi_word = '0;
        end
        if (err) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_err: actual=err required=none");
          end else begin
            e = sb.pop_front();
            chk("kind_err", {31'd0, e.is_err}, 32'd1);
            chk("err_ready_low", {31'd0, ready}, 32'd0);
            chk("err_after_ready", {31'd0, prev_ready}, 32'd1);
            chk("err_req_len", ready_cnt, TO + 1);
            chk("err_no_shift", shift_cnt + nbits, 0);
            chk("err_rx_hold", rx_data, last_rx);
          end
          ready_cnt = 0; shift_cnt = 0; nbits = 0; mosi_word = '0;
        end
        prev_sclk = sclk; prev_ready = ready; prev_done = done;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_wait: actual=busy required=idle within %0d cycles", budget);
    end
  endtask

  task automatic do_xfer(input logic [DW-1:0] tx, input logic [DW-1:0] rx, input int dly,
                         input bit to, input bit poke, input bit rst_mid);
    exp_t e;
    wait_idle(SHIFT_CYC + TO + 20);
    @(negedge clk);
    send = 1'b1; tx_data = tx; cur_rx = rx;
    @(posedge clk);
    #1;
    send = 1'b0;
    chk("req_up", {30'd0, ready, busy}, 32'd3);
    n_req++;
    if (!rst_mid) begin
      e.is_err = to; e.tx = tx; e.rx = rx; e.req = to ? TO + 1 : dly + 1;
      sb.push_back(e);
    end
    if (!to) begin
      repeat (dly) @(posedge clk);
      @(negedge clk);
      start_man = 1'b1;
      @(posedge clk);
      #1;
      chk("ack_ready_cs", {30'd0, ready, cs_n}, 32'd0);
      @(negedge clk);
      start_man = 1'b0;
      if (poke) begin
        repeat (10) @(negedge clk);
        send = 1'b1; tx_data = ~tx;
        @(negedge clk);
        send = 1'b0; tx_data = tx;
      end
      if (rst_mid) begin
        repeat (2 * CD * 3 - 1) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_mid_shift", {busy, ready, done, rx_valid, err, sclk, mosi, cs_n, rx_data}, 32'h0100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    end
    wait_idle(SHIFT_CYC + TO + 20);
  endtask

  initial begin : stim
    logic [DW-1:0] w, r;
    int base_r, base_d, n;
    #12;
    rst = 1'b1;
    #1;
    chk("reset_async", {busy, ready, done, rx_valid, err, sclk, mosi, cs_n, rx_data}, 32'h0100);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_xfer(8'hA5, 8'h3C, 2, 1'b0, 1'b0, 1'b0);
    do_xfer(DW'($urandom), DW'($urandom), TO, 1'b0, 1'b0, 1'b0);
    do_xfer(DW'($urandom), DW'($urandom), 0, 1'b1, 1'b0, 1'b0);
    do_xfer(8'h00, DW'($urandom), 1, 1'b0, 1'b1, 1'b0);
    do_xfer(DW'($urandom), DW'($urandom), 1, 1'b0, 1'b0, 1'b1);
    do_xfer(8'h81, DW'($urandom), 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      do_xfer(DW'($urandom), DW'($urandom), $urandom_range(0, TO),
              ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

    // send held high with an immediately acknowledging slave
    w = DW'($urandom); r = DW'($urandom);
    @(negedge clk);
    cur_rx = r; tx_data = w; auto_start = 1'b1; send = 1'b1;
    sb.push_back('{1'b0, w, r, 1});
    sb.push_back('{1'b0, w, r, 1});
    n_req += 2;
    base_r = ready_rises; base_d = n_done;
    n = 0;
    while (ready_rises < base_r + 2 && n < 4 * SHIFT_CYC) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (n_done < base_d + 2 && n < 4 * SHIFT_CYC) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_done_count", n_done - base_d, 2);
    if (n_done >= base_d + 2)
      chk("b2b_spacing", done_cyc[base_d+1] - done_cyc[base_d], SHIFT_CYC + 3);
    auto_start = 1'b0;
    wait_idle(SHIFT_CYC + TO + 20);
    repeat (5) @(posedge clk);
    #1;

    chk("pending_expected", sb.size(), 0);
    chk("request_count", ready_rises, n_req);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
